alu_driver: RTL and testbench

ALU_DRIVER -- requirements
Module: alu_driver

---
 rtl/alu_driver.sv | 159 +++++++++++++++
 tb/tb_alu_driver.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_driver.sv
`default_nettype none
// ============================================================================
//  Module      : alu_driver
//  Description : Single-outstanding command driver for a fixed-latency ALU.
//                Accepts one command, holds the ALU operands for LAT+1
//                edges, captures the ALU result/status into a response
//                register and waits for the consumer handshake. Keeps a
//                saturating count of responses that reported ERROR.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_driver #(
   parameter int BITS = 8,
   parameter int LAT  = 2
) (
   input  logic            i_clk,
   input  logic            i_rst,
   // command channel
   input  logic            i_cmd_valid,
   output logic            o_cmd_ready,
   input  logic [1:0]      i_cmd_op,
   input  logic [BITS-1:0] i_cmd_a,
   input  logic [BITS-1:0] i_cmd_b,
   // ALU side
   output logic [BITS-1:0] o_alu_a,
   output logic [BITS-1:0] o_alu_b,
   output logic [1:0]      o_alu_op,
   input  logic [BITS-1:0] i_alu_out,
   input  logic [3:0]      i_alu_status,
   // response channel
   output logic            o_rsp_valid,
   input  logic            i_rsp_ready,
   output logic [BITS-1:0] o_rsp_out,
   output logic [3:0]      o_rsp_status,
   output logic [1:0]      o_rsp_op,
   // status
   output logic            o_busy,
   output logic [7:0]      o_err_cnt
);

   // Counter is 4 bits wide: LAT is limited to 1..15.
   localparam int         c_CNT_W   = 4;
   localparam logic [3:0] c_LAT     = 4'(LAT);
   localparam logic [7:0] c_ERR_MAX = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [c_CNT_W-1:0]   r_cnt;
   logic [BITS-1:0]      r_alu_a;
   logic [BITS-1:0]      r_alu_b;
   logic [1:0]           r_alu_op;
   logic                 r_rsp_valid;
   logic [BITS-1:0]      r_rsp_out;
   logic [3:0]           r_rsp_status;
   logic [1:0]           r_rsp_op;
   logic [7:0]           r_err_cnt;

   logic                 w_accept;
   logic                 w_capture;
   logic                 w_release;

   // Handshake qualifiers; each is only meaningful in its own state, which
   // is what makes cmd_valid/rsp_ready inert elsewhere.
   assign w_accept  = i_cmd_valid && (r_state == ST_IDLE);
   assign w_capture = (r_state == ST_WAIT) && (r_cnt == '0);
   assign w_release = i_rsp_ready && (r_state == ST_RESP);

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state logic and state-decoded handshake outputs.
   always_comb begin
      w_state_nxt = r_state;
      o_cmd_ready = 1'b0;
      o_busy      = 1'b1;
      case (r_state)
         ST_IDLE: begin
            o_cmd_ready = 1'b1;
            o_busy      = 1'b0;
            if (i_cmd_valid) w_state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (r_cnt == '0) w_state_nxt = ST_RESP;
         end
         ST_RESP: begin
            if (i_rsp_ready) w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Latency counter: loaded with LAT on accept, counts down to 0, and the
   // edge that sees 0 is the capture edge (accept edge + LAT + 1).
   always_ff @(posedge i_clk) begin
      if (i_rst)                                 r_cnt <= '0;
      else if (w_accept)                         r_cnt <= c_LAT;
      else if (r_state == ST_WAIT && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
   end

   // Operand registers: only written on accept, so they stay put through
   // WAIT, RESP and the following IDLE.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_alu_a  <= '0;
         r_alu_b  <= '0;
         r_alu_op <= '0;
      end else if (w_accept) begin
         r_alu_a  <= i_cmd_a;
         r_alu_b  <= i_cmd_b;
         r_alu_op <= i_cmd_op;
      end
   end

   // Response register: ALU outputs are sampled only on the capture edge.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rsp_valid  <= 1'b0;
         r_rsp_out    <= '0;
         r_rsp_status <= '0;
         r_rsp_op     <= '0;
      end else if (w_capture) begin
         r_rsp_valid  <= 1'b1;
         r_rsp_out    <= i_alu_out;
         r_rsp_status <= i_alu_status;
         r_rsp_op     <= r_alu_op;
      end else if (w_release) begin
         r_rsp_valid  <= 1'b0;
      end
   end

   // Saturating count of captured responses flagged ERROR.
   always_ff @(posedge i_clk) begin
      if (i_rst)
         r_err_cnt <= '0;
      else if (w_capture && i_alu_status[0] && r_err_cnt != c_ERR_MAX)
         r_err_cnt <= r_err_cnt + 8'd1;
   end

   assign o_alu_a      = r_alu_a;
   assign o_alu_b      = r_alu_b;
   assign o_alu_op     = r_alu_op;
   assign o_rsp_valid  = r_rsp_valid;
   assign o_rsp_out    = r_rsp_out;
   assign o_rsp_status = r_rsp_status;
   assign o_rsp_op     = r_rsp_op;
   assign o_err_cnt    = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alu_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_driver
//  Description : Directed self-checking bench for alu_driver. Three
//                instances (LAT=2, LAT=1, LAT=4) share command operands and
//                the ALU result inputs; each has its own handshakes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_driver;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] cmd_op = '0;
   logic [7:0] cmd_a = '0, cmd_b = '0;
   logic [7:0] alu_out = '0;
   logic [3:0] alu_status = '0;

   logic       cv0 = 0, rr0 = 0, cv1 = 0, rr1 = 0, cv4 = 0, rr4 = 0;
   logic       cr0, rv0, b0, cr1, rv1, b1, cr4, rv4, b4;
   logic [7:0] aa0, ab0, ro0, ec0, aa1, ab1, ro1, ec1, aa4, ab4, ro4, ec4;
   logic [1:0] ao0, rop0, ao1, rop1, ao4, rop4;
   logic [3:0] rs0, rs1, rs4;

   int checks = 0;
   int errors = 0;
   int resp_cnt = 0;

   always #5 clk = ~clk;

   alu_driver #(.BITS(8), .LAT(2)) u_dut2 (
      .i_clk(clk), .i_rst(rst), .i_cmd_valid(cv0), .o_cmd_ready(cr0),
      .i_cmd_op(cmd_op), .i_cmd_a(cmd_a), .i_cmd_b(cmd_b),
      .o_alu_a(aa0), .o_alu_b(ab0), .o_alu_op(ao0),
      .i_alu_out(alu_out), .i_alu_status(alu_status),
      .o_rsp_valid(rv0), .i_rsp_ready(rr0), .o_rsp_out(ro0),
      .o_rsp_status(rs0), .o_rsp_op(rop0), .o_busy(b0), .o_err_cnt(ec0));

   alu_driver #(.BITS(8), .LAT(1)) u_dut1 (
      .i_clk(clk), .i_rst(rst), .i_cmd_valid(cv1), .o_cmd_ready(cr1),
      .i_cmd_op(cmd_op), .i_cmd_a(cmd_a), .i_cmd_b(cmd_b),
      .o_alu_a(aa1), .o_alu_b(ab1), .o_alu_op(ao1),
      .i_alu_out(alu_out), .i_alu_status(alu_status),
      .o_rsp_valid(rv1), .i_rsp_ready(rr1), .o_rsp_out(ro1),
      .o_rsp_status(rs1), .o_rsp_op(rop1), .o_busy(b1), .o_err_cnt(ec1));

   alu_driver #(.BITS(8), .LAT(4)) u_dut4 (
      .i_clk(clk), .i_rst(rst), .i_cmd_valid(cv4), .o_cmd_ready(cr4),
      .i_cmd_op(cmd_op), .i_cmd_a(cmd_a), .i_cmd_b(cmd_b),
      .o_alu_a(aa4), .o_alu_b(ab4), .o_alu_op(ao4),
      .i_alu_out(alu_out), .i_alu_status(alu_status),
      .o_rsp_valid(rv4), .i_rsp_ready(rr4), .o_rsp_out(ro4),
      .o_rsp_status(rs4), .o_rsp_op(rop4), .o_busy(b4), .o_err_cnt(ec4));

   // Count completed response handshakes of the LAT=2 instance.
   always @(posedge clk) if (!rst && rv0 && rr0) resp_cnt++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Operand-hold and latency check on the LAT=1 (sel=1) or LAT=4 instance.
   task automatic run_lat(input int sel, input int lat);
      int n;
      cmd_op = 2'b10; cmd_a = 8'h3C; cmd_b = 8'hC3;
      alu_out = 8'h81; alu_status = 4'b1000;
      if (sel == 1) cv1 = 1; else cv4 = 1;
      tick();
      cv1 = 0; cv4 = 0;
      cmd_op = 2'b01; cmd_a = 8'h00; cmd_b = 8'hFF;
      n = 0;
      do begin
         check($sformatf("hold_lat%0d_n%0d", lat, n),
               (sel == 1) ? {14'd0, ao1, ab1, aa1} : {14'd0, ao4, ab4, aa4},
               {14'd0, 2'b10, 8'hC3, 8'h3C});
         tick();
         n++;
      end while (!((sel == 1) ? rv1 : rv4) && n < 20);
      check($sformatf("lat%0d_cycles", lat), n, lat + 1);
      check($sformatf("lat%0d_rsp", lat),
            (sel == 1) ? {18'd0, rop1, rs1, ro1} : {18'd0, rop4, rs4, ro4},
            {18'd0, 2'b10, 4'b1000, 8'h81});
      if (sel == 1) rr1 = 1; else rr4 = 1;
      tick();
      rr1 = 0; rr4 = 0;
      check($sformatf("lat%0d_idle", lat), (sel == 1) ? cr1 : cr4, 1);
   endtask

   initial begin
      int exp_err;
      int saved_resp;

      // ---------------- reset state
      tick(); tick();
      rst = 0;
      check("rst_cmd_ready", cr0, 1);
      check("rst_busy", b0, 0);
      check("rst_rsp_valid", rv0, 0);
      check("rst_alu", {ao0, ab0, aa0}, 0);
      check("rst_rsp", {rop0, rs0, ro0}, 0);
      check("rst_err_cnt", ec0, 0);

      // ---------------- basic: 5 - 3 on LAT=2
      cmd_op = 2'b00; cmd_a = 8'd5; cmd_b = 8'd3; cv0 = 1;
      alu_out = 8'hEE; alu_status = 4'b0001;
      tick();                                   // accept edge E0
      check("acc_busy", b0, 1);
      check("acc_ready", cr0, 0);
      check("acc_alu", {ao0, ab0, aa0}, {2'b00, 8'd3, 8'd5});
      // second command during WAIT must be ignored
      cmd_op = 2'b01; cmd_a = 8'hAA; cmd_b = 8'h55; cv0 = 1;
      tick();                                   // E0+1
      check("w1_rsp_valid", rv0, 0);
      check("w1_alu_a", aa0, 8'd5);
      tick();                                   // E0+2
      check("w2_rsp_valid", rv0, 0);
      alu_out = 8'd2; alu_status = 4'b0010;
      tick();                                   // E0+3 capture
      check("cap_rsp_valid", rv0, 1);
      check("cap_rsp", {rop0, rs0, ro0}, {2'b00, 4'b0010, 8'd2});
      check("cap_err_cnt", ec0, 0);
      alu_out = 8'h77; alu_status = 4'b0101;    // late change must not matter

      // ---------------- backpressure
      for (int i = 0; i < 5; i++) begin
         if (i == 3) cv0 = 0;
         tick();
         check($sformatf("bp%0d_rsp", i), {rv0, rop0, rs0, ro0}, {1'b1, 2'b00, 4'b0010, 8'd2});
         check($sformatf("bp%0d_ready_busy", i), {cr0, b0}, 2'b01);
      end
      rr0 = 1;
      tick();
      rr0 = 0;
      check("rel_rsp_valid", rv0, 0);
      check("rel_ready_busy", {cr0, b0}, 2'b10);
      check("rel_alu_hold", {ao0, ab0, aa0}, {2'b00, 8'd3, 8'd5});
      check("resp_count", resp_cnt, 1);
      tick();
      check("idle_hold", {cr0, aa0}, {1'b1, 8'd5});

      // ---------------- reset in WAIT
      cmd_op = 2'b11; cmd_a = 8'd9; cmd_b = 8'd1; cv0 = 1;
      tick();
      cv0 = 0;
      check("mid_accept", aa0, 8'd9);
      rst = 1;
      tick();
      rst = 0;
      check("mid_rst_alu", {ao0, ab0, aa0}, 0);
      check("mid_rst_rsp", {rv0, rop0, rs0, ro0}, 0);
      check("mid_rst_ready_busy", {cr0, b0}, 2'b10);
      saved_resp = resp_cnt;
      rr0 = 1;
      for (int i = 0; i < 6; i++) begin
         tick();
         check($sformatf("mid_no_rsp%0d", i), rv0, 0);
      end
      rr0 = 0;
      check("mid_resp_count", resp_cnt, saved_resp);

      // ---------------- saturating error count
      exp_err = 0;
      for (int k = 1; k <= 257; k++) begin
         cmd_op = 2'(k); cmd_a = 8'(k); cmd_b = 8'd0; cv0 = 1;
         alu_out = 8'(k); alu_status = 4'b0001;
         tick();
         cv0 = 0;
         tick(); tick(); tick();
         exp_err = (exp_err < 255) ? exp_err + 1 : 255;
         check($sformatf("err%0d", k), {rv0, ro0, ec0}, {1'b1, 8'(k), 8'(exp_err)});
         rr0 = 1;
         tick();
         rr0 = 0;
      end
      cmd_op = 2'b01; cv0 = 1; alu_status = 4'b1110;
      tick();
      cv0 = 0;
      tick(); tick(); tick();
      check("err_clean", {rv0, rs0, ec0}, {1'b1, 4'b1110, 8'd255});
      rr0 = 1;
      tick();
      rr0 = 0;

      // ---------------- operand hold / latency for LAT=1 and LAT=4
      run_lat(1, 1);
      run_lat(4, 4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
